// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and default sizes for the SLC-3 RAM port arbiter.
// Holds the arbitration FSM state enum, the access-owner enum and the
// default address/data widths used by the arbiter and its interface.
package ram_arb_pkg;

  localparam int RAM_ARB_ADDR_W = 10;
  localparam int RAM_ARB_DATA_W = 16;

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    IDLE    = 3'd1,
    ACC_CPU = 3'd2,
    ACC_DBG = 3'd3,
    RD_WAIT = 3'd4
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters, the init-data source
// and the single-port RAM. The arbiter connects through the slave modport;
// everything around it (CPU, debug reader, init source, RAM) uses master.
interface ram_arb_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);

  logic [ADDR_W-1:0] init_ADDR;
  logic [DATA_W-1:0] init_data;
  logic              init_done;

  logic              cpu_req;
  logic              cpu_we;
  logic [15:0]       cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;

  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data;
  logic              ram_rden;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;

  modport slave (
    output init_ADDR, init_done,
    input  init_data,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dbg_req, dbg_addr,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output ram_address, ram_data, ram_rden, ram_wren,
    input  ram_q
  );

  modport master (
    input  init_ADDR, init_done,
    output init_data,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output dbg_req, dbg_addr,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  ram_address, ram_data, ram_rden, ram_wren,
    output ram_q
  );

endinterface

// File: rtl/ram_port_arbiter_init_seq.sv
// RAM initialization sequencer. After reset it waits one cycle, then walks
// the address counter from 0 to the last word, one word per cycle, and
// parks once the pass is complete until the next reset.
module ram_init_seq #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] init_addr,
  output logic              init_busy,
  output logic              init_last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic [ADDR_W-1:0] cnt;
  logic              armed;
  logic              finished;

  // Address counter: one start-up cycle after reset, then count to the end.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      armed    <= 1'b0;
      finished <= 1'b0;
    end else if (!finished) begin
      if (!armed) begin
        armed <= 1'b1;
      end else if (cnt == LAST_ADDR) begin
        finished <= 1'b1;
        cnt      <= '0;
      end else begin
        cnt <= cnt + ADDR_W'(1);
      end
    end
  end

  assign init_addr = cnt;
  assign init_busy = armed && !finished;
  assign init_last = init_busy && (cnt == LAST_ADDR);

endmodule

// File: rtl/ram_port_arbiter.sv
// Sequencer and arbiter for the single-port SLC-3 RAM (1-cycle read latency).
// After reset it writes every RAM word from the init-data source, then shares
// the port between the CPU and a read-only debug requester.
// Build option RAM_ARB_DBG_EN: when defined the debug port and round-robin
// arbitration are present; when undefined the debug outputs are tied to 0 and
// the CPU wins every arbitration sample.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = RAM_ARB_ADDR_W,
  parameter int DATA_W = RAM_ARB_DATA_W
) (
  input logic    Clk,
  input logic    Reset,
  ram_arb_if.slave bus
);

  arb_state_t        state;
  arb_state_t        state_nxt;

  logic [ADDR_W-1:0] init_addr;
  logic              init_busy;
  logic              init_last;

  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_we;
  owner_t            lat_owner;

  logic              cpu_win;
  logic              dbg_win;

  logic              init_done_q;
  logic              cpu_rvalid_q;
  logic [DATA_W-1:0] cpu_rdata_q;

  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data;
  logic              ram_rden;
  logic              ram_wren;
  logic              cpu_gnt;
  logic              dbg_gnt;

  logic              inputs_unused;

  ram_init_seq #(.ADDR_W(ADDR_W)) u_init_seq (
    .clk       (Clk),
    .rst       (Reset),
    .init_addr (init_addr),
    .init_busy (init_busy),
    .init_last (init_last)
  );

`ifdef RAM_ARB_DBG_EN
  owner_t            last_owner;
  logic              dbg_rvalid_q;
  logic [DATA_W-1:0] dbg_rdata_q;

  // On a tie the requester that did not get the port last time wins.
  assign cpu_win = bus.cpu_req && (!bus.dbg_req || (last_owner == OWN_DBG));
  assign dbg_win = bus.dbg_req && (!bus.cpu_req || (last_owner == OWN_CPU));

  assign inputs_unused = ^bus.cpu_addr[15:ADDR_W];

  // Round-robin pointer; starts at DBG so the CPU wins the first tie.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_owner <= OWN_DBG;
    end else if (state == IDLE) begin
      if (cpu_win) begin
        last_owner <= OWN_CPU;
      end else if (dbg_win) begin
        last_owner <= OWN_DBG;
      end
    end
  end

  // Debug read data capture and its one-cycle valid pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= '0;
    end else begin
      dbg_rvalid_q <= 1'b0;
      if ((state == RD_WAIT) && (lat_owner == OWN_DBG)) begin
        dbg_rdata_q  <= bus.ram_q;
        dbg_rvalid_q <= 1'b1;
      end
    end
  end

  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.dbg_rvalid = dbg_rvalid_q;
  assign bus.dbg_rdata  = dbg_rdata_q;
`else
  assign cpu_win = bus.cpu_req;
  assign dbg_win = 1'b0;

  assign inputs_unused = ^{bus.cpu_addr[15:ADDR_W], bus.dbg_req, bus.dbg_addr, dbg_gnt, dbg_win};

  assign bus.dbg_gnt    = 1'b0;
  assign bus.dbg_rvalid = 1'b0;
  assign bus.dbg_rdata  = '0;
`endif

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Latch the winning request so the RAM is driven from registered values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      lat_owner <= OWN_CPU;
    end else if (state == IDLE) begin
      if (cpu_win) begin
        lat_addr  <= bus.cpu_addr[ADDR_W-1:0];
        lat_wdata <= bus.cpu_wdata;
        lat_we    <= bus.cpu_we;
        lat_owner <= OWN_CPU;
      end
`ifdef RAM_ARB_DBG_EN
      else if (dbg_win) begin
        lat_addr  <= bus.dbg_addr;
        lat_wdata <= '0;
        lat_we    <= 1'b0;
        lat_owner <= OWN_DBG;
      end
`endif
    end
  end

  // Sticky init-done flag plus CPU read data capture and valid pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      init_done_q  <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
    end else begin
      cpu_rvalid_q <= 1'b0;
      if ((state == INIT) && init_last) begin
        init_done_q <= 1'b1;
      end
      if ((state == RD_WAIT) && (lat_owner == OWN_CPU)) begin
        cpu_rdata_q  <= bus.ram_q;
        cpu_rvalid_q <= 1'b1;
      end
    end
  end

  // Next-state logic, RAM port muxing and grant pulses.
  always_comb begin
    state_nxt   = state;
    ram_address = '0;
    ram_data    = '0;
    ram_rden    = 1'b0;
    ram_wren    = 1'b0;
    cpu_gnt     = 1'b0;
    dbg_gnt     = 1'b0;
    case (state)
      INIT: begin
        ram_address = init_addr;
        ram_data    = bus.init_data;
        ram_wren    = init_busy;
        if (init_last) begin
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        if (cpu_win) begin
          state_nxt = ACC_CPU;
        end else if (dbg_win) begin
          state_nxt = ACC_DBG;
        end
      end
      ACC_CPU: begin
        ram_address = lat_addr;
        ram_data    = lat_wdata;
        cpu_gnt     = 1'b1;
        if (lat_we) begin
          ram_wren  = 1'b1;
          state_nxt = IDLE;
        end else begin
          ram_rden  = 1'b1;
          state_nxt = RD_WAIT;
        end
      end
`ifdef RAM_ARB_DBG_EN
      ACC_DBG: begin
        ram_address = lat_addr;
        dbg_gnt     = 1'b1;
        ram_rden    = 1'b1;
        state_nxt   = RD_WAIT;
      end
`endif
      RD_WAIT: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = INIT;
      end
    endcase
  end

  assign bus.init_ADDR   = init_addr;
  assign bus.init_done   = init_done_q;
  assign bus.cpu_gnt     = cpu_gnt;
  assign bus.cpu_rvalid  = cpu_rvalid_q;
  assign bus.cpu_rdata   = cpu_rdata_q;
  assign bus.ram_address = ram_address;
  assign bus.ram_data    = ram_data;
  assign bus.ram_rden    = ram_rden;
  assign bus.ram_wren    = ram_wren;

endmodule
